axis_packet_echo: RTL and testbench

Store-and-forward AXI4-Stream loopback stage for the PG080 AXI4-Stream FIFO test design on the Arty. It consumes packets from the FIFO core's transmit stream, buffers each packet completely, and returns it on the FIFO core's receive stream followed by one trailer word that carries the received word count. The AXI-MM test bench can then write a packet through the FIFO's TX registers and read back a known, length-tagged packet through its RX registers.

---
 rtl/axis_packet_echo.sv | 209 ++++++++++++++++++++
 tb/tb_axis_packet_echo.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_echo.sv
// Store-and-forward AXI4-Stream echo: buffers one packet, replays it, then appends
// a trailer word {8'hA5, 8'h00, length} with tlast set.
module axis_packet_echo #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] pkt_count,
    output logic        overflow,
    input  logic        clear
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;

    // Handshake rule on both streams: a word transfers on a rising edge where
    // tvalid && tready; the m_axis side holds tdata/tlast/tvalid until that edge.
    typedef enum logic [1:0] {
        RECV  = 2'd0,
        DROP  = 2'd1,
        SEND  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic                  active_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [LW-1:0]         len_q;
    logic [LW-1:0]         rd_ptr_q;
    logic [LW-1:0]         sent_q;
    logic                  trail_issued_q;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           ram_q;

    logic                  rd_pend_q;
    logic                  rd_pend_trail_q;

    logic                  out_valid_q;
    logic                  out_last_q;
    logic [31:0]           out_data_q;
    logic                  skid_valid_q;
    logic                  skid_last_q;
    logic [31:0]           skid_data_q;

    logic                  in_fire;
    logic                  out_fire;
    logic                  wr_full;
    logic                  recv_fire;
    logic                  trunc_fire;
    logic                  trail_fire;
    logic [1:0]            occ;
    logic                  can_issue;
    logic                  issue_data;
    logic                  issue_trail;
    logic [15:0]           len16;
    logic [31:0]           trailer_word;
    logic [31:0]           arr_data;

    assign s_axis_tready = active_q && ((state_q == RECV) || (state_q == DROP));
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign out_fire      = out_valid_q && m_axis_tready;
    assign wr_full       = (wr_ptr_q == ADDR_WIDTH'(DEPTH - 1));
    assign recv_fire     = in_fire && (state_q == RECV);
    assign trunc_fire    = recv_fire && !s_axis_tlast && wr_full;
    assign trail_fire    = out_fire && (state_q == TRAIL);

    assign len16         = 16'(len_q);
    assign trailer_word  = {8'hA5, 8'h00, len16};
    assign arr_data      = rd_pend_trail_q ? trailer_word : ram_q;

    // Items held after this edge plus the one still in the RAM read; a new read
    // is only launched when it is guaranteed a slot in the out/skid pair.
    assign occ = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pend_q}
               - {1'b0, out_fire};
    assign can_issue   = (state_q == SEND) && !trail_issued_q && (occ < 2'd2);
    assign issue_data  = can_issue && (rd_ptr_q != len_q);
    assign issue_trail = can_issue && (rd_ptr_q == len_q);

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= RECV;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RECV: begin
                if (in_fire) begin
                    if (s_axis_tlast) state_d = SEND;
                    else if (wr_full) state_d = DROP;
                end
            end
            DROP: begin
                if (in_fire && s_axis_tlast) state_d = SEND;
            end
            SEND: begin
                if (out_fire && (sent_q == len_q - LW'(1))) state_d = TRAIL;
            end
            TRAIL: begin
                if (out_fire) state_d = RECV;
            end
            default: state_d = RECV;
        endcase
    end

    // Packet buffer: write port from s_axis, registered read port for replay.
    always_ff @(posedge aclk) begin
        if (recv_fire) mem[wr_ptr_q] <= s_axis_tdata;
        if (issue_data) ram_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q        <= '0;
            len_q           <= '0;
            rd_ptr_q        <= '0;
            sent_q          <= '0;
            trail_issued_q  <= 1'b0;
            rd_pend_q       <= 1'b0;
            rd_pend_trail_q <= 1'b0;
        end else begin
            rd_pend_q       <= issue_data || issue_trail;
            rd_pend_trail_q <= issue_trail;
            if (recv_fire) begin
                wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
                if (s_axis_tlast) len_q <= LW'(wr_ptr_q) + LW'(1);
                else if (wr_full) len_q <= LW'(DEPTH);
            end
            if (issue_data) rd_ptr_q <= rd_ptr_q + LW'(1);
            if (issue_trail) trail_issued_q <= 1'b1;
            if (out_fire && (state_q == SEND)) sent_q <= sent_q + LW'(1);
            if (trail_fire) begin
                wr_ptr_q       <= '0;
                rd_ptr_q       <= '0;
                sent_q         <= '0;
                trail_issued_q <= 1'b0;
            end
        end
    end

    // Output register with a one-word skid so the stream keeps full rate.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            if (out_fire || !out_valid_q) begin
                if (skid_valid_q) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= skid_data_q;
                    out_last_q  <= skid_last_q;
                    if (rd_pend_q) begin
                        skid_data_q <= arr_data;
                        skid_last_q <= rd_pend_trail_q;
                    end else begin
                        skid_valid_q <= 1'b0;
                    end
                end else if (rd_pend_q) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= arr_data;
                    out_last_q  <= rd_pend_trail_q;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (rd_pend_q) begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= arr_data;
                skid_last_q  <= rd_pend_trail_q;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_count <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            pkt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (trail_fire) pkt_count <= pkt_count + 16'd1;
            if (trunc_fire) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_packet_echo.sv
// Directed bench for axis_packet_echo at a 16-word buffer: echo, trailer, overflow,
// backpressure, mid-packet reset and clear/trailer collision.
module tb_axis_packet_echo;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [15:0] pkt_count;
    logic        overflow;
    logic        clear;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          stab_viol = 0;
    bit          timeout;
    logic [31:0] tx_q[$];
    logic [31:0] exp_q[$];
    logic        exp_l[$];
    logic [31:0] got_d[$];
    logic        got_l[$];

    axis_packet_echo #(.ADDR_WIDTH(4)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_count     (pkt_count),
        .overflow      (overflow),
        .clear         (clear)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Output stream stability monitor: a stalled word must stay put.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_d;
    logic        prev_l;
    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && (!m_axis_tvalid || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l))
                stab_viol++;
            prev_hold = m_axis_tvalid && !m_axis_tready;
            prev_d    = m_axis_tdata;
            prev_l    = m_axis_tlast;
        end
    end

    task automatic send_pkt(input bit rand_valid, input bit use_last);
        int n;
        int waitc;
        int gap;
        n = tx_q.size();
        for (int i = 0; i < n; i++) begin
            if (rand_valid) begin
                s_axis_tvalid = 1'b0;
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    @(posedge aclk);
                    #1;
                end
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = tx_q[i];
            s_axis_tlast  = use_last && (i == n - 1);
            waitc = 0;
            @(negedge aclk);
            while (!s_axis_tready && waitc < 1000) begin
                @(negedge aclk);
                waitc++;
            end
            if (waitc >= 1000) timeout = 1'b1;
            @(posedge aclk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic collect(input bit rand_ready, input bit clr_on_last,
                           output int cycles, output int first_cyc);
        bit done;
        got_d.delete();
        got_l.delete();
        cycles = 0;
        first_cyc = -1;
        done = 1'b0;
        while (!done) begin
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge aclk);
            if (m_axis_tvalid && m_axis_tready) begin
                if (first_cyc < 0) first_cyc = cycles;
                got_d.push_back(m_axis_tdata);
                got_l.push_back(m_axis_tlast);
                if (m_axis_tlast) begin
                    done = 1'b1;
                    if (clr_on_last) clear = 1'b1;
                end
            end
            @(posedge aclk);
            #1;
            clear = 1'b0;
            cycles++;
            if (cycles > 2000) begin
                timeout = 1'b1;
                done = 1'b1;
            end
        end
        m_axis_tready = 1'b0;
    endtask

    task automatic build_exp(input bit [15:0] len);
        exp_q.delete();
        exp_l.delete();
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back(tx_q[i]);
            exp_l.push_back(1'b0);
        end
        exp_q.push_back({8'hA5, 8'h00, len});
        exp_l.push_back(1'b1);
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0; clear = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        n_checks++; if (s_axis_tready !== 1'b0) $display("FAIL rst_s_tready: got %b expected 0", s_axis_tready); else n_pass++;
        n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_m_tvalid: got %b expected 0", m_axis_tvalid); else n_pass++;
        n_checks++; if (m_axis_tdata !== 32'h0) $display("FAIL rst_m_tdata: got %h expected 0", m_axis_tdata); else n_pass++;
        n_checks++; if (m_axis_tlast !== 1'b0) $display("FAIL rst_m_tlast: got %b expected 0", m_axis_tlast); else n_pass++;
        n_checks++; if (pkt_count !== 16'd0) $display("FAIL rst_pkt_count: got %0d expected 0", pkt_count); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b expected 0", overflow); else n_pass++;
        aresetn = 1'b1;
        #1;
        n_checks++; if (s_axis_tready !== 1'b0) $display("FAIL rel_s_tready_pre: got %b expected 0", s_axis_tready); else n_pass++;
        @(posedge aclk);
        #1;
        n_checks++; if (s_axis_tready !== 1'b1) $display("FAIL rel_s_tready: got %b expected 1", s_axis_tready); else n_pass++;
    endtask

    task automatic test_single_4;
        int cyc, first;
        timeout = 1'b0;
        tx_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        exp_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'hA5000004};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        send_pkt(1'b0, 1'b1);
        collect(1'b0, 1'b0, cyc, first);
        n_checks++; if (timeout !== 1'b0) $display("FAIL p4_timeout: got %b expected 0", timeout); else n_pass++;
        n_checks++; if (got_d.size() != 5) $display("FAIL p4_size: got %0d expected 5", got_d.size()); else n_pass++;
        for (int i = 0; i < got_d.size() && i < 5; i++) begin
            n_checks++; if (got_d[i] !== exp_q[i]) $display("FAIL p4_data[%0d]: got %h expected %h", i, got_d[i], exp_q[i]); else n_pass++;
            n_checks++; if (got_l[i] !== exp_l[i]) $display("FAIL p4_last[%0d]: got %b expected %b", i, got_l[i], exp_l[i]); else n_pass++;
        end
        n_checks++; if (first != 2) $display("FAIL p4_latency: got %0d expected 2", first); else n_pass++;
        n_checks++; if (cyc != 7) $display("FAIL p4_gapless: got %0d cycles expected 7", cyc); else n_pass++;
        n_checks++; if (pkt_count !== 16'd1) $display("FAIL p4_pkt_count: got %0d expected 1", pkt_count); else n_pass++;
    endtask

    task automatic test_single_word;
        int cyc, first;
        timeout = 1'b0;
        tx_q = '{32'hDEADBEEF};
        send_pkt(1'b0, 1'b1);
        collect(1'b0, 1'b0, cyc, first);
        n_checks++; if (got_d.size() != 2) $display("FAIL p1_size: got %0d expected 2", got_d.size()); else n_pass++;
        if (got_d.size() == 2) begin
            n_checks++; if (got_d[0] !== 32'hDEADBEEF || got_l[0] !== 1'b0) $display("FAIL p1_word: got %h/%b expected deadbeef/0", got_d[0], got_l[0]); else n_pass++;
            n_checks++; if (got_d[1] !== 32'hA5000001 || got_l[1] !== 1'b1) $display("FAIL p1_trailer: got %h/%b expected a5000001/1", got_d[1], got_l[1]); else n_pass++;
        end
        n_checks++; if (cyc != 4) $display("FAIL p1_cycles: got %0d expected 4", cyc); else n_pass++;
        n_checks++; if (pkt_count !== 16'd2) $display("FAIL p1_pkt_count: got %0d expected 2", pkt_count); else n_pass++;
    endtask

    task automatic test_overflow;
        int cyc, first;
        timeout = 1'b0;
        tx_q.delete();
        for (int i = 0; i < 20; i++) tx_q.push_back(32'h1000_0000 + 32'(i));
        build_exp(16'd16);
        send_pkt(1'b0, 1'b1);
        collect(1'b0, 1'b0, cyc, first);
        n_checks++; if (timeout !== 1'b0) $display("FAIL ovf_timeout: got %b expected 0", timeout); else n_pass++;
        n_checks++; if (got_d.size() != 17) $display("FAIL ovf_size: got %0d expected 17", got_d.size()); else n_pass++;
        for (int i = 0; i < got_d.size() && i < 17; i++) begin
            n_checks++; if (got_d[i] !== exp_q[i] || got_l[i] !== exp_l[i]) $display("FAIL ovf_word[%0d]: got %h/%b expected %h/%b", i, got_d[i], got_l[i], exp_q[i], exp_l[i]); else n_pass++;
        end
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow); else n_pass++;
        n_checks++; if (pkt_count !== 16'd3) $display("FAIL ovf_pkt_count: got %0d expected 3", pkt_count); else n_pass++;
        tx_q = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
        send_pkt(1'b0, 1'b1);
        collect(1'b0, 1'b0, cyc, first);
        n_checks++; if (got_d.size() != 4 || got_d[3] !== 32'hA5000003) $display("FAIL ovf_next_trailer: got %0d words, last %h expected 4 words, a5000003", got_d.size(), got_d[got_d.size()-1]); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow); else n_pass++;
        n_checks++; if (pkt_count !== 16'd4) $display("FAIL ovf_next_count: got %0d expected 4", pkt_count); else n_pass++;
        clear = 1'b1;
        @(posedge aclk);
        #1;
        clear = 1'b0;
        n_checks++; if (overflow !== 1'b0) $display("FAIL clr_overflow: got %b expected 0", overflow); else n_pass++;
        n_checks++; if (pkt_count !== 16'd0) $display("FAIL clr_pkt_count: got %0d expected 0", pkt_count); else n_pass++;
    endtask

    task automatic test_random;
        int cyc, first;
        int len;
        timeout = 1'b0;
        stab_viol = 0;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 16);
            tx_q.delete();
            for (int i = 0; i < len; i++) tx_q.push_back($urandom);
            build_exp(16'(len));
            send_pkt(1'b1, 1'b1);
            collect(1'b1, 1'b0, cyc, first);
            n_checks++; if (got_d.size() != len + 1) $display("FAIL rnd_size p%0d: got %0d expected %0d", p, got_d.size(), len + 1); else n_pass++;
            for (int i = 0; i < got_d.size() && i <= len; i++) begin
                n_checks++; if (got_d[i] !== exp_q[i] || got_l[i] !== exp_l[i]) $display("FAIL rnd_word p%0d[%0d]: got %h/%b expected %h/%b", p, i, got_d[i], got_l[i], exp_q[i], exp_l[i]); else n_pass++;
            end
        end
        n_checks++; if (timeout !== 1'b0) $display("FAIL rnd_timeout: got %b expected 0", timeout); else n_pass++;
        n_checks++; if (stab_viol != 0) $display("FAIL rnd_stability: got %0d violations expected 0", stab_viol); else n_pass++;
        n_checks++; if (pkt_count !== 16'd100) $display("FAIL rnd_pkt_count: got %0d expected 100", pkt_count); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int cyc, first;
        int seen;
        timeout = 1'b0;
        tx_q = '{32'hBAD00001, 32'hBAD00002, 32'hBAD00003};
        send_pkt(1'b0, 1'b0);
        aresetn = 1'b0;
        #1;
        n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL mid_rst_tvalid: got %b expected 0", m_axis_tvalid); else n_pass++;
        n_checks++; if (pkt_count !== 16'd0) $display("FAIL mid_rst_count: got %0d expected 0", pkt_count); else n_pass++;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge aclk);
            if (m_axis_tvalid) seen++;
        end
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b0;
        n_checks++; if (seen != 0) $display("FAIL mid_no_trailer: got %0d valid cycles expected 0", seen); else n_pass++;
        tx_q = '{32'h0000AAAA, 32'h0000BBBB};
        build_exp(16'd2);
        send_pkt(1'b0, 1'b1);
        collect(1'b0, 1'b0, cyc, first);
        n_checks++; if (got_d.size() != 3) $display("FAIL mid_size: got %0d expected 3", got_d.size()); else n_pass++;
        for (int i = 0; i < got_d.size() && i < 3; i++) begin
            n_checks++; if (got_d[i] !== exp_q[i] || got_l[i] !== exp_l[i]) $display("FAIL mid_word[%0d]: got %h/%b expected %h/%b", i, got_d[i], got_l[i], exp_q[i], exp_l[i]); else n_pass++;
        end
        n_checks++; if (pkt_count !== 16'd1) $display("FAIL mid_pkt_count: got %0d expected 1", pkt_count); else n_pass++;
    endtask

    task automatic test_clear_on_trailer;
        int cyc, first;
        timeout = 1'b0;
        tx_q = '{32'h01234567, 32'h89ABCDEF, 32'h02468ACE};
        send_pkt(1'b0, 1'b1);
        collect(1'b0, 1'b1, cyc, first);
        n_checks++; if (got_d.size() != 4 || got_d[3] !== 32'hA5000003) $display("FAIL clr_trl_trailer: got %0d words, last %h expected 4 words, a5000003", got_d.size(), got_d[got_d.size()-1]); else n_pass++;
        n_checks++; if (pkt_count !== 16'd0) $display("FAIL clr_trl_count: got %0d expected 0", pkt_count); else n_pass++;
        n_checks++; if (timeout !== 1'b0) $display("FAIL clr_trl_timeout: got %b expected 0", timeout); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_4();
        test_single_word();
        test_overflow();
        test_random();
        test_reset_mid();
        test_clear_on_trailer();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
